spi_dep_reset_sequencer: RTL and testbench

- Controls reset release for the SPI-side logic domains. The input reset is already synchronized on deassertion.
- Releases NUM_DOMAINS active-low domain resets one at a time, in a fixed order, with a programmable spacing between releases.
- Provides a hold input and a software reset request. Both re-assert all domains and then repeat the release sequence.
- Placed directly after the reset synchronizer. Its outputs drive the reset pins of the downstream domains.

---
 rtl/spi_dep_reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_spi_dep_reset_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_dep_reset_sequencer.sv
// Staged reset-release sequencer for the SPI-side logic domains.
// Domain resets are released one at a time, bit 0 first, spaced by a
// delay that is latched once per sequence. A hold level or an accepted
// software request re-asserts every domain and restarts the sequence.
// Every output comes straight from a flop so the reset pins see no glitches.
module spi_dep_reset_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int DELAY_W     = 8,
  parameter int SW_PULSE    = 4
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   hold_i,
  input  logic                   sw_reset_req_i,
  input  logic [DELAY_W-1:0]     delay_i,
  output logic [NUM_DOMAINS-1:0] domain_nreset_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sw_ack_o
);

  localparam int STAGE_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_DOMAINS - 1);
  localparam logic [DELAY_W-1:0] SW_CNT     = DELAY_W'(SW_PULSE);
  localparam logic [DELAY_W-1:0] ONE        = DELAY_W'(1);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT      = 2'd1,
    S_RUN       = 2'd2,
    S_SW_ASSERT = 2'd3
  } state_e;

  state_e                   state_q,  state_d;
  logic [STAGE_W-1:0]       stage_q,  stage_d;
  logic [DELAY_W-1:0]       cnt_q,    cnt_d;
  logic [DELAY_W-1:0]       delay_q,  delay_d;
  logic [NUM_DOMAINS-1:0]   domain_q, domain_d;
  logic                     busy_q,   busy_d;
  logic                     done_q,   done_d;
  logic                     ack_q,    ack_d;
  logic [DELAY_W-1:0]       fresh_delay;

  // A programmed delay of 0 behaves like 1 so the counter never wraps.
  assign fresh_delay = (delay_i == '0) ? ONE : delay_i;

  // Next-state and next-output decode; hold has priority over the software request.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    domain_d = domain_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ack_d    = 1'b0;

    if (hold_i) begin
      state_d  = S_HOLD;
      stage_d  = '0;
      cnt_d    = '0;
      domain_d = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          state_d = S_WAIT;
          delay_d = fresh_delay;
          cnt_d   = fresh_delay;
          stage_d = '0;
        end

        S_WAIT: begin
          if (cnt_q <= ONE) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (stage_q == STAGE_W'(i)) domain_d[i] = 1'b1;
            end
            cnt_d = delay_q;
            if (stage_q == LAST_STAGE) begin
              state_d = S_RUN;
              stage_d = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + STAGE_W'(1);
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end

        S_RUN: begin
          if (sw_reset_req_i) begin
            state_d  = S_SW_ASSERT;
            cnt_d    = SW_CNT;
            domain_d = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            ack_d    = 1'b1;
          end
        end

        S_SW_ASSERT: begin
          if (cnt_q <= ONE) begin
            state_d = S_WAIT;
            delay_d = fresh_delay;
            cnt_d   = fresh_delay;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end

        default: state_d = S_HOLD;
      endcase
    end
  end

  // State and output registers; reset forces every domain back into reset at once.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q  <= S_HOLD;
      stage_q  <= '0;
      cnt_q    <= '0;
      delay_q  <= ONE;
      domain_q <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      stage_q  <= stage_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      domain_q <= domain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
    end
  end

  assign domain_nreset_o = domain_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign sw_ack_o        = ack_q;

endmodule

// File: tb/tb_spi_dep_reset_sequencer.sv
// Directed bench for spi_dep_reset_sequencer (3 domains, 8-bit delay, SW_PULSE 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// following the rising edge under test. Edge numbers are relative to a base
// set whenever the sequence is (re)started from HOLD.
module tb_spi_dep_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       nreset_i;
  logic       hold_i;
  logic       sw_reset_req_i;
  logic [7:0] delay_i;
  logic [2:0] domain_nreset_o;
  logic       busy_o;
  logic       done_o;
  logic       sw_ack_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  spi_dep_reset_sequencer #(
    .NUM_DOMAINS(3),
    .DELAY_W    (8),
    .SW_PULSE   (4)
  ) dut (
    .clk_i          (clk_i),
    .nreset_i       (nreset_i),
    .hold_i         (hold_i),
    .sw_reset_req_i (sw_reset_req_i),
    .delay_i        (delay_i),
    .domain_nreset_o(domain_nreset_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .sw_ack_o       (sw_ack_o)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  // Free-running count of rising edges.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Safety net in case the bench ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: the next rising edge becomes edge 0.
  task automatic rebase();
    base = cyc;
  endtask

  // Return on the falling edge after rising edge k.
  task automatic wait_edge(input int k);
    while (cyc < base + 1 + k) @(negedge clk_i);
  endtask

  initial begin
    nreset_i       = 1'b0;
    hold_i         = 1'b0;
    sw_reset_req_i = 1'b0;
    delay_i        = 8'd4;
    repeat (3) @(negedge clk_i);

    // Reset state
    chk("rst_domain", 32'(domain_nreset_o), 32'h0);
    chk("rst_busy",   32'(busy_o),          32'h1);
    chk("rst_done",   32'(done_o),          32'h0);
    chk("rst_ack",    32'(sw_ack_o),        32'h0);

    // Basic sequence, D = 4: releases at 4, 8, 12
    nreset_i = 1'b1;
    rebase();
    wait_edge(3);  chk("d4_e3_dom",  32'(domain_nreset_o), 32'h0);
                   chk("d4_e3_busy", 32'(busy_o),          32'h1);
    wait_edge(4);  chk("d4_e4_dom",  32'(domain_nreset_o), 32'h1);
    wait_edge(7);  chk("d4_e7_dom",  32'(domain_nreset_o), 32'h1);
    wait_edge(8);  chk("d4_e8_dom",  32'(domain_nreset_o), 32'h3);
    wait_edge(11); chk("d4_e11_dom", 32'(domain_nreset_o), 32'h3);
                   chk("d4_e11_done", 32'(done_o),         32'h0);
                   chk("d4_e11_busy", 32'(busy_o),         32'h1);
    wait_edge(12); chk("d4_e12_dom", 32'(domain_nreset_o), 32'h7);
                   chk("d4_e12_done", 32'(done_o),         32'h1);
                   chk("d4_e12_busy", 32'(busy_o),         32'h0);

    // Software request at edge 20: ack pulse, releases at 28, 32, 36
    wait_edge(19); sw_reset_req_i = 1'b1;
    wait_edge(20); sw_reset_req_i = 1'b0;
                   chk("sw_e20_dom",  32'(domain_nreset_o), 32'h0);
                   chk("sw_e20_ack",  32'(sw_ack_o),        32'h1);
                   chk("sw_e20_busy", 32'(busy_o),          32'h1);
                   chk("sw_e20_done", 32'(done_o),          32'h0);
    wait_edge(21); chk("sw_e21_ack",  32'(sw_ack_o),        32'h0);
    wait_edge(27); chk("sw_e27_dom",  32'(domain_nreset_o), 32'h0);
    wait_edge(28); chk("sw_e28_dom",  32'(domain_nreset_o), 32'h1);
    wait_edge(32); chk("sw_e32_dom",  32'(domain_nreset_o), 32'h3);
    wait_edge(35); chk("sw_e35_dom",  32'(domain_nreset_o), 32'h3);
    wait_edge(36); chk("sw_e36_dom",  32'(domain_nreset_o), 32'h7);
                   chk("sw_e36_done", 32'(done_o),          32'h1);

    // hold together with a software request in RUN: hold wins, no ack
    wait_edge(37); hold_i = 1'b1; sw_reset_req_i = 1'b1;
    wait_edge(38); sw_reset_req_i = 1'b0;
                   chk("hsw_dom",  32'(domain_nreset_o), 32'h0);
                   chk("hsw_ack",  32'(sw_ack_o),        32'h0);
                   chk("hsw_busy", 32'(busy_o),          32'h1);
                   chk("hsw_done", 32'(done_o),          32'h0);
    wait_edge(40); chk("hsw_e40_dom", 32'(domain_nreset_o), 32'h0);

    // Fresh sequence; delay_i moves to 9 before edge 5 and a request hits edge 6
    hold_i = 1'b0;
    delay_i = 8'd4;
    rebase();
    wait_edge(4);  chk("mid_e4_dom", 32'(domain_nreset_o), 32'h1);
                   delay_i = 8'd9;
    wait_edge(5);  sw_reset_req_i = 1'b1;
    wait_edge(6);  sw_reset_req_i = 1'b0;
                   chk("mid_e6_ack", 32'(sw_ack_o),        32'h0);
    wait_edge(7);  chk("mid_e7_dom", 32'(domain_nreset_o), 32'h1);
    wait_edge(8);  chk("mid_e8_dom", 32'(domain_nreset_o), 32'h3);
    wait_edge(11); chk("mid_e11_dom", 32'(domain_nreset_o), 32'h3);
    wait_edge(12); chk("mid_e12_dom", 32'(domain_nreset_o), 32'h7);

    // Return to HOLD, then restart and hold mid-sequence at edge 10
    hold_i = 1'b1;
    wait_edge(13); chk("hold_run_dom", 32'(domain_nreset_o), 32'h0);
    hold_i  = 1'b0;
    delay_i = 8'd4;
    rebase();
    wait_edge(8);  chk("hw_e8_dom", 32'(domain_nreset_o), 32'h3);
    wait_edge(9);  chk("hw_e9_dom", 32'(domain_nreset_o), 32'h3);
                   hold_i = 1'b1;
    wait_edge(10); chk("hw_e10_dom",  32'(domain_nreset_o), 32'h0);
                   chk("hw_e10_busy", 32'(busy_o),          32'h1);
    wait_edge(11); chk("hw_e11_dom",  32'(domain_nreset_o), 32'h0);

    // delay_i = 0 behaves as 1: releases at 1, 2, 3
    hold_i  = 1'b0;
    delay_i = 8'd0;
    rebase();
    wait_edge(0);  chk("d0_e0_dom", 32'(domain_nreset_o), 32'h0);
    wait_edge(1);  chk("d0_e1_dom", 32'(domain_nreset_o), 32'h1);
    wait_edge(2);  chk("d0_e2_dom", 32'(domain_nreset_o), 32'h3);
                   chk("d0_e2_done", 32'(done_o),         32'h0);
    wait_edge(3);  chk("d0_e3_dom", 32'(domain_nreset_o), 32'h7);
                   chk("d0_e3_done", 32'(done_o),         32'h1);

    // Asynchronous reset between edges mid-sequence
    hold_i = 1'b1;
    wait_edge(4);
    hold_i  = 1'b0;
    delay_i = 8'd4;
    rebase();
    wait_edge(5);  chk("ar_e5_dom", 32'(domain_nreset_o), 32'h1);
    #2 nreset_i = 1'b0;
    #1 chk("ar_async_dom",  32'(domain_nreset_o), 32'h0);
       chk("ar_async_busy", 32'(busy_o),          32'h1);
       chk("ar_async_done", 32'(done_o),          32'h0);
    @(negedge clk_i);
    chk("ar_held_dom", 32'(domain_nreset_o), 32'h0);

    // Full sequence repeats after reset release
    nreset_i = 1'b1;
    rebase();
    wait_edge(3);  chk("ar2_e3_dom",  32'(domain_nreset_o), 32'h0);
    wait_edge(4);  chk("ar2_e4_dom",  32'(domain_nreset_o), 32'h1);
    wait_edge(8);  chk("ar2_e8_dom",  32'(domain_nreset_o), 32'h3);
    wait_edge(12); chk("ar2_e12_dom", 32'(domain_nreset_o), 32'h7);
                   chk("ar2_e12_done", 32'(done_o),         32'h1);
                   chk("ar2_e12_busy", 32'(busy_o),         32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
